// File: rtl/rio_uart_tx.sv
// 8N1 UART transmitter for the CPU's register I/O output port.
// A small byte FIFO absorbs write bursts; dropped writes raise a sticky overflow flag.
module rio_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       ovf_clr,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [FIFO_DEPTH-1:0][7:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt;
    logic          baud_end;

    // full is taken from the pre-edge count, so a concurrent pop never rescues a push
    assign full = (count == DEPTH_C);
    assign push = wr_en & ~full;
    assign busy = (state != IDLE) | (count != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en && full) overflow <= 1'b1;
            else if (ovf_clr)  overflow <= 1'b0;
        end
    end

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    baud_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the same edge as the FSM
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_rio_uart_tx.sv
// Directed bench for rio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Line/busy/full are logged once per cycle; frames are compared cycle by cycle against hand-built patterns.
module tb_rio_uart_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx, busy, full, overflow;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic txlog   [4096];
    logic busylog [4096];
    logic fulllog [4096];

    rio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .ovf_clr(ovf_clr), .tx(tx), .busy(busy), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen; logs hold values settled after edge cyc
    initial forever begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        txlog[cyc]   = tx;
        busylog[cyc] = busy;
        fulllog[cyc] = full;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
        wr_data = 8'hEE;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    // Frame starting at cycle s: start 0, data LSB first, stop 1, 4 cycles each; line high just before
    task automatic check_frame(input string tag, input int s, input logic [7:0] b);
        logic [39:0] obs, exp;
        for (int c = 0; c < 40; c++) begin
            obs[c] = txlog[s + c];
            if (c < 4)       exp[c] = 1'b0;
            else if (c < 36) exp[c] = b[(c - 4) / 4];
            else             exp[c] = 1'b1;
        end
        chk({tag, "_pre"}, txlog[s - 1], 1'b1);
        chk(tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag, input int a, input int z);
        logic all_hi, any_busy;
        all_hi = 1'b1;
        any_busy = 1'b0;
        for (int c = a; c <= z; c++) begin
            all_hi   = all_hi & txlog[c];
            any_busy = any_busy | busylog[c];
        end
        chk({tag, "_tx"}, all_hi, 1'b1);
        chk({tag, "_busy"}, any_busy, 1'b0);
    endtask

    initial begin
        int e, s, r;
        logic any_full;

        // reset state
        tick(); tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        tick();

        // single frame 0xA5
        e = cyc + 1;
        push(8'hA5);
        chk("a5_busy_after_push", busy, 1'b1);
        wait_cyc(e + 42);
        check_frame("a5_frame", e + 1, 8'hA5);
        chk("a5_busy_last_stop", busylog[e + 40], 1'b1);
        chk("a5_busy_fall", busylog[e + 41], 1'b0);

        // three back-to-back frames, one idle cycle between
        e = cyc + 1;
        push(8'h01); push(8'h80); push(8'hFF);
        s = e + 1;
        wait_cyc(s + 125);
        check_frame("b2b_01", s, 8'h01);
        check_frame("b2b_80", s + 41, 8'h80);
        check_frame("b2b_ff", s + 82, 8'hFF);
        any_full = 1'b0;
        for (int c = e; c <= s + 122; c++) any_full = any_full | fulllog[c];
        chk("b2b_never_full", any_full, 1'b0);

        // overflow: six pushes, one pop in between, last one dropped
        e = cyc + 1;
        push(8'h10); push(8'h11); push(8'h12); push(8'h13); push(8'h14);
        chk("ovf_full", full, 1'b1);
        chk("ovf_not_yet", overflow, 1'b0);
        push(8'h15);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_still_full", full, 1'b1);
        // clear together with another drop: set wins
        wr_en = 1'b1; wr_data = 8'h99; ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("ovf_set_wins", overflow, 1'b1);
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);
        s = e + 1;
        wait_cyc(s + 164 + 50);
        check_frame("ovf_f10", s,       8'h10);
        check_frame("ovf_f11", s + 41,  8'h11);
        check_frame("ovf_f12", s + 82,  8'h12);
        check_frame("ovf_f13", s + 123, 8'h13);
        check_frame("ovf_f14", s + 164, 8'h14);
        check_quiet("ovf_drained", s + 204, s + 214);

        // reset during data bit 0 of 0x3C with two bytes queued
        e = cyc + 1;
        push(8'h3C); push(8'h11); push(8'h22);
        wait_cyc(e + 6);
        chk("mid_tx_low", tx, 1'b0);
        chk("mid_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_tx", tx, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_full", full, 1'b0);
        tick(); tick();
        reset = 1'b0;
        r = cyc;
        wait_cyc(r + 60);
        check_quiet("post_rst", r + 1, r + 60);

        // push during the IDLE pop with two bytes queued: count holds at 2
        e = cyc + 1;
        push(8'hC3); push(8'h5A); push(8'hE7);
        s = e + 1;
        wait_cyc(s + 40);
        push(8'h96);
        push(8'h42);
        chk("pp_count3_not_full", full, 1'b0);
        push(8'h24);
        chk("pp_count4_full", full, 1'b1);
        wait_cyc(s + 252);
        check_frame("pp_c3", s,       8'hC3);
        check_frame("pp_5a", s + 41,  8'h5A);
        check_frame("pp_e7", s + 82,  8'hE7);
        check_frame("pp_96", s + 123, 8'h96);
        check_frame("pp_42", s + 164, 8'h42);
        check_frame("pp_24", s + 205, 8'h24);
        check_quiet("pp_end", s + 245, s + 250);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rio_uart_tx.md
Name: rio_uart_tx

Overview:
- Serial transmitter for the 88bit CPU's register I/O output port. Sends each byte the CPU writes to its I/O register to a host computer as 8N1 UART.
- Sits between the CPU core and the board TX pin.
- A small FIFO decouples CPU write bursts from the serial line rate.
- A sticky flag reports bytes lost to FIFO overflow.

Parameters:
CLKS_PER_BIT, 234, clock cycles per serial bit (27 MHz / 115200 baud); must be >= 2
FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  one-cycle strobe; CPU is writing its I/O register this cycle
wr_data  input  8  byte being written (the CPU's rio_out value)
ovf_clr  input  1  clears the overflow flag
tx  output  1  UART serial out; idle high
busy  output  1  high while the FIFO is non-empty or a frame is in flight
full  output  1  high when the FIFO holds FIFO_DEPTH bytes
overflow  output  1  sticky; set when a write was dropped

Behaviour:
- Reset (asynchronous, immediate):
  - tx=1, busy=0, full=0, overflow=0.
  - FIFO emptied, FSM in IDLE, bit and baud counters cleared.
  - Reset mid-frame aborts the frame and drives tx high at once. No partial frame resumes after reset is released.
- FIFO push:
  - On a clk edge with wr_en=1 and full=0, wr_data is written at the tail and count increments.
  - If full=1 on that edge, the byte is dropped and overflow is set.
  - A push on a full FIFO is dropped even if a pop occurs on the same edge. full is evaluated from the pre-edge count.
- Overflow flag:
  - Stays set until an edge with ovf_clr=1.
  - If ovf_clr=1 and a drop occur on the same edge, set wins.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop when not full: both take effect and count is unchanged.
- full = (count == FIFO_DEPTH).
- busy = (state != IDLE) | (count != 0).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. On an edge with count != 0: load the head byte into the shift register, pop it, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right and the index increments. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Latency:
  - A byte pushed at edge E into an empty FIFO with the FSM idle is popped at edge E+1; tx falls at that edge.
  - Total frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames: IDLE lasts exactly one cycle between a STOP and the next START. The line gap is CLKS_PER_BIT+1 high cycles including the stop bit.
- tx is driven from a register (glitch-free). No combinational path from inputs to tx.
- wr_data is captured only on a push. Later changes on wr_data do not affect queued bytes.

Test Plan:
- CLKS_PER_BIT=4, reset, then wr_en with wr_data=0xA5 -> tx low one cycle after the push edge. Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 high cycles. busy falls one cycle after STOP ends. Total 40 cycles low-to-end.
- Push 0x01, 0x80, 0xFF on consecutive cycles -> three frames in order, each separated by exactly one IDLE cycle. full never asserts with FIFO_DEPTH=4.
- FIFO_DEPTH=4, push 6 bytes 0x10..0x15 in consecutive cycles. First pop occurs at push 2, so 0x15 is dropped -> overflow=1, full observed high. Transmitted sequence is 0x10..0x14.
- overflow=1, assert ovf_clr together with a dropped write -> overflow stays 1. Next ovf_clr alone -> 0.
- Assert reset mid-DATA of 0x3C with two more bytes queued -> tx=1, busy=0 and full=0 immediately, with no clock. After release, line stays high with no further frames.
- Push and pop on the same edge with count=2 (new push arriving as IDLE pops) -> count stays 2 and byte order is preserved.
